// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side byte buffer placed directly after uart_rx. Each rising edge of
// rx_done captures one byte into a DEPTH-entry first-word-fall-through FIFO.
// The host reads bytes over a valid/ready port. The block also reports
// occupancy, full/empty status and a sticky overflow flag for dropped bytes.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   rx_done   in   byte-complete strobe (pulse or level; rising edge used)
//   data_in   in   received byte, sampled on the edge that sees rx_done rise
//   rd_ready  in   consumer accepts rd_data this cycle
//   rd_valid  out  rd_data holds the oldest unread byte
//   rd_data   out  head-of-FIFO byte (combinational read)
//   count     out  number of stored bytes, 0..DEPTH
//   empty     out  count == 0
//   full      out  count == DEPTH
//   overflow  out  sticky: a byte was dropped while full
//   ovf_clr   in   synchronous clear of overflow (a same-cycle set wins)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE_C = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE_C = {{ADDR_W{1'b0}}, 1'b1};

    // State registers
    logic                rx_done_q;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q,  count_d;
    logic                overflow_q, overflow_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Decoded control
    logic wr_req_s;
    logic pop_s;
    logic wr_en_s;
    logic drop_s;
    logic empty_s;
    logic full_s;

    // Status is derived from count alone; pointers are never compared.
    assign empty_s  = (count_q == {(ADDR_W+1){1'b0}});
    assign full_s   = (count_q == DEPTH_C);

    // One write request per rx_done assertion, however long it is held.
    assign wr_req_s = rx_done & ~rx_done_q;
    assign pop_s    = ~empty_s & rd_ready;
    // A full FIFO still accepts a write when a pop frees a slot this cycle.
    assign wr_en_s  = wr_req_s & (~full_s | pop_s);
    assign drop_s   = wr_req_s & full_s & ~pop_s;

    assign rd_valid = ~empty_s;
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = empty_s;
    assign full     = full_s;
    assign overflow = overflow_q;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE_C;
            2'b01:   count_d = count_q - CNT_ONE_C;
            default: count_d = count_q;
        endcase

        // Setting takes priority over a same-cycle clear.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control registers. rx_done_q resets high so that an rx_done already
    // asserted when reset is released does not look like a new byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_done_q  <= 1'b1;
            wr_ptr_q   <= {ADDR_W{1'b0}};
            rd_ptr_q   <= {ADDR_W{1'b0}};
            count_q    <= {(ADDR_W+1){1'b0}};
            overflow_q <= 1'b0;
        end else begin
            rx_done_q  <= rx_done;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array. It is cleared on reset so that rd_data reads 0 while
    // the FIFO has never been written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= data_in;
            end
        end
    end

    uart_rx_fifo_chk #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_chk (
        .clk      (clk),
        .reset    (reset),
        .count    (count_q),
        .empty    (empty_s),
        .full     (full_s),
        .rd_valid (rd_valid),
        .wr_req   (wr_req_s),
        .pop      (pop_s),
        .drop     (drop_s)
    );

endmodule

// ---------------------------------------------------------------------------
// uart_rx_fifo_chk
// Structural invariants of uart_rx_fifo: occupancy bound, status consistency
// and the mutual exclusion between a dropped byte and a pop.
//
// Ports
//   clk, reset   clock and active-low reset of the checked block
//   count        occupancy
//   empty, full  status flags
//   rd_valid     read-port valid
//   wr_req       detected rx_done rising edge
//   pop          accepted read
//   drop         byte discarded because the FIFO was full
// ---------------------------------------------------------------------------
module uart_rx_fifo_chk #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic            clk,
    input logic            reset,
    input logic [ADDR_W:0] count,
    input logic            empty,
    input logic            full,
    input logic            rd_valid,
    input logic            wr_req,
    input logic            pop,
    input logic            drop
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    // Occupancy never exceeds the number of entries.
    a_count_bound: assert property (@(posedge clk) disable iff (!reset)
        count <= DEPTH_C);

    // Status flags agree with the occupancy.
    a_empty_flag: assert property (@(posedge clk) disable iff (!reset)
        empty == (count == {(ADDR_W+1){1'b0}}));

    a_full_flag: assert property (@(posedge clk) disable iff (!reset)
        full == (count == DEPTH_C));

    a_valid_flag: assert property (@(posedge clk) disable iff (!reset)
        rd_valid == !empty);

    // A byte is only dropped on a write request into a full FIFO with no pop.
    a_drop_cause: assert property (@(posedge clk) disable iff (!reset)
        drop |-> (wr_req && full && !pop));

endmodule
